// File: rtl/aes_key_sched_seq.sv
// aes_key_sched_seq: sequential AES key expansion (128/192/256-bit keys).
// One schedule word is computed per clock; all words are kept in an internal
// store and any round key can be read back through a small read port.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request expansion; accepted only in IDLE
//   key_len    00 AES-128, 01 AES-192, 10 AES-256, 11 reserved
//   key        cipher key, MSB-first, word 0 = key[255:224]
//   rk_idx     round-key index for the read port (0..nr)
//   busy       high while words are being generated
//   done       one-cycle pulse on the edge that writes the last word
//   keys_valid sticky flag: a complete schedule is stored
//   rk         round key rk_idx (zero when rk_valid is low)
//   rk_valid   keys_valid and rk_idx <= nr
//   err        one-cycle pulse when start is rejected for key_len=11
//
// Handshake: start is a level sampled on every rising edge; it is acted on
// only when the FSM is in IDLE, so holding or re-pulsing it while busy has no
// effect. done/err are single-cycle pulses with no acknowledge. rk/rk_valid
// follow rk_idx either one cycle later (OUT_REG=1) or in the same cycle.
module aes_key_sched_seq #(
    parameter int OUT_REG   = 1,
    parameter int CHECK_LEN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    input  logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic [127:0] rk,
    output logic         rk_valid,
    output logic         err
);

    // FIPS-197 S-box, entry x at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, FINISH = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] store [0:59];
    logic [3:0]  nk_q, nr_q;
    logic [5:0]  last_q;          // index of the final word, TOTAL-1
    logic [5:0]  i_q;             // index of the word written this cycle
    logic [2:0]  j_q;             // position within the nk-word period
    logic [7:0]  rcon_q;
    logic        kv_q;
    logic        err_q;

    // Per-length constants, looked up rather than derived arithmetically.
    logic [3:0] nk_d, nr_d;
    logic [5:0] last_d;
    always_comb begin
        nk_d   = 4'd4;
        nr_d   = 4'd10;
        last_d = 6'd43;
        case (key_len)
            2'b01:   begin nk_d = 4'd6; nr_d = 4'd12; last_d = 6'd51; end
            2'b10:   begin nk_d = 4'd8; nr_d = 4'd14; last_d = 6'd59; end
            default: ;
        endcase
    end

    logic legal, accept, reject, last_word;
    assign legal     = (key_len != 2'b11);
    assign accept    = (state_q == IDLE) && start && legal;
    assign reject    = (state_q == IDLE) && start && !legal && (CHECK_LEN != 0);
    assign last_word = (i_q == last_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXPAND;
            EXPAND:  if (last_word) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word datapath: one shared 4-byte S-box serves both the RotWord case
    // (j==0) and the extra AES-256 SubWord at j==4.
    logic [31:0] w_prev, w_back, sub_in, sub_out, temp, new_word;
    logic        j_wrap;
    logic [7:0]  rcon_next;
    always_comb begin
        w_prev  = store[i_q - 6'd1];
        w_back  = store[i_q - {2'b00, nk_q}];
        sub_in  = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                   sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
        temp    = w_prev;
        if (j_q == 3'd0)
            temp = sub_out ^ {rcon_q, 24'h0};
        else if ((nk_q == 4'd8) && (j_q == 3'd4))
            temp = sub_out;
        new_word  = w_back ^ temp;
        j_wrap    = ({1'b0, j_q} == (nk_q - 4'd1));
        rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            nk_q    <= 4'd4;
            nr_q    <= 4'd0;
            last_q  <= 6'd0;
            i_q     <= 6'd0;
            j_q     <= 3'd0;
            rcon_q  <= 8'h01;
            kv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= reject;
            if (accept) begin
                nk_q   <= nk_d;
                nr_q   <= nr_d;
                last_q <= last_d;
                i_q    <= {2'b00, nk_d};
                j_q    <= 3'd0;
                rcon_q <= 8'h01;
                kv_q   <= 1'b0;
            end else if (state_q == EXPAND) begin
                i_q <= i_q + 6'd1;
                j_q <= j_wrap ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0) rcon_q <= rcon_next;
                if (last_word)   kv_q   <= 1'b1;
            end
        end
    end

    // Word store has no reset. All eight key words are loaded on accept;
    // for shorter keys the surplus ones are overwritten during expansion.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 8; k++)
                store[k] <= key[255 - 32*k -: 32];
        end else if (state_q == EXPAND) begin
            store[i_q] <= new_word;
        end
    end

    // Round-key read port. Word indices are formed by OR-ing into the zero
    // low bits of 4*rk_idx.
    logic [5:0]   base;
    logic [127:0] rd_words;
    logic         rk_hit;
    assign base     = {rk_idx, 2'b00};
    assign rd_words = {store[base], store[base | 6'd1], store[base | 6'd2], store[base | 6'd3]};
    assign rk_hit   = kv_q && (rk_idx <= nr_q);

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [127:0] rk_r;
            logic         rk_valid_r;
            // Masking with accept keeps rk_valid from lingering a cycle
            // after a new schedule has been started.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rk_r       <= '0;
                    rk_valid_r <= 1'b0;
                end else begin
                    rk_valid_r <= rk_hit && !accept;
                    rk_r       <= (rk_hit && !accept) ? rd_words : '0;
                end
            end
            assign rk       = rk_r;
            assign rk_valid = rk_valid_r;
        end else begin : g_out_comb
            assign rk       = rk_hit ? rd_words : '0;
            assign rk_valid = rk_hit;
        end
    endgenerate

    assign busy       = (state_q == EXPAND);
    assign done       = (state_q == FINISH);
    assign keys_valid = kv_q;
    assign err        = err_q;

endmodule

// File: tb/tb_aes_key_sched_seq.sv
module tb_aes_key_sched_seq;

  localparam int OUT_REG   = 1;
  localparam int CHECK_LEN = 1;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [128:0] ALL  = '1;
  localparam logic [128:0] LOWW = {1'b1, 96'h0, 32'hffffffff};

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'b00;
  logic [255:0] key = '0;
  logic [3:0]   rk_idx = 4'd0;
  logic         busy, done, keys_valid, rk_valid, err;
  logic [127:0] rk;

  aes_key_sched_seq #(.OUT_REG(OUT_REG), .CHECK_LEN(CHECK_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
    .rk_idx(rk_idx), .busy(busy), .done(done), .keys_valid(keys_valid),
    .rk(rk), .rk_valid(rk_valid), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [128:0] exp_q[$];
  logic [128:0] msk_q[$];
  int           done_q[$];
  int           blen_q[$];
  int           err_q[$];
  logic         errkv_q[$];
  logic rd_req = 1'b0;
  logic rd_tag = 1'b0;
  int   busy_cnt = 0;

  always @(posedge clk) rd_tag <= rd_req;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sb_tab [256];
  logic [31:0] mw [60];
  int          mdl_nk = 4, mdl_nr = 10, mdl_total = 44;
  bit          mdl_valid = 1'b0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < n; k++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic void model_expand(input logic [1:0] len, input logic [255:0] k);
    mdl_nk    = 4 + 2 * int'(len);
    mdl_nr    = mdl_nk + 6;
    mdl_total = 4 * (mdl_nr + 1);
    for (int i = 0; i < mdl_nk; i++) mw[i] = k[255 - 32*i -: 32];
    for (int i = mdl_nk; i < mdl_total; i++) begin
      logic [31:0] t;
      t = mw[i-1];
      if (i % mdl_nk == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / mdl_nk), 24'h0};
      else if (mdl_nk > 6 && i % mdl_nk == 4)
        t = sub_word(t);
      mw[i] = mw[i - mdl_nk] ^ t;
    end
  endfunction

  function automatic logic [128:0] expected_rd(input logic [3:0] idx);
    int b;
    b = 4 * int'(idx);
    if (mdl_valid && int'(idx) <= mdl_nr) return {1'b1, mw[b], mw[b+1], mw[b+2], mw[b+3]};
    return '0;
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < 8; i++) k = {k[223:0], 32'($urandom())};
    return k;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [128:0] e, m;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (done_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_done: done=1 at edge %0d, expected no done", cyc);
        end else begin
          check("done_edge", 160'(cyc), 160'(done_q.pop_front()));
          check("busy_cycles", 160'(busy_cnt), 160'(blen_q.pop_front()));
          check("keys_valid_at_done", 160'(keys_valid), 160'(1));
        end
        busy_cnt = 0;
      end
      if (err) begin
        if (err_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_err: err=1 at edge %0d, expected 0", cyc);
        end else begin
          check("err_edge", 160'(cyc), 160'(err_q.pop_front()));
          check("busy_at_err", 160'(busy), 160'(0));
          check("kv_at_err", 160'(keys_valid), 160'(errkv_q.pop_front()));
        end
      end
      if ((OUT_REG != 0) ? rd_tag : rd_req) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rk_read: output seen with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          m = msk_q.pop_front();
          check("rk_read", 160'({rk_valid, rk} & m), 160'(e & m));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic [3:0] idx);
    rk_idx = idx;
    rd_req = 1'b1;
    exp_q.push_back(expected_rd(idx));
    msk_q.push_back(ALL);
  endtask

  task automatic read_one(input logic [3:0] idx);
    push_read(idx);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic read_kat(input logic [3:0] idx, input logic [128:0] e, input logic [128:0] m);
    rk_idx = idx;
    rd_req = 1'b1;
    exp_q.push_back(e);
    msk_q.push_back(m);
    tick();
    rd_req = 1'b0;
    tick();
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) read_one(4'(i));
    tick();
  endtask

  task automatic start_run(input logic [1:0] len, input logic [255:0] k, input bit with_read);
    int e;
    e = cyc + 1;
    key_len = len;
    key     = k;
    start   = 1'b1;
    if (len != 2'b11) begin
      model_expand(len, k);
      mdl_valid = 1'b0;
      done_q.push_back(e + mdl_total - mdl_nk);
      blen_q.push_back(mdl_total - mdl_nk);
    end else begin
      err_q.push_back(e);
      errkv_q.push_back(mdl_valid);
    end
    if (with_read) push_read(4'($urandom_range(0, 15)));
    tick();
    start  = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (done_q.size() != 0 && c < 200) begin
      tick();
      c++;
    end
    if (done_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout: no done within %0d cycles", c);
      done_q.delete();
      blen_q.delete();
    end else begin
      mdl_valid = 1'b1;
    end
    tick();
  endtask

  // mode 0: quiet; 1: random start/key noise while busy; 2: reads while busy
  task automatic run(input logic [1:0] len, input logic [255:0] k, input int mode);
    start_run(len, k, mode == 2);
    for (int c = 1; c < mdl_total - mdl_nk; c++) begin
      if (mode == 1 && $urandom_range(0, 2) == 0) begin
        start   = 1'b1;
        key     = rand_key();
        key_len = 2'($urandom_range(0, 3));
      end
      if (mode == 2 && c < 6) push_read(4'($urandom_range(0, 15)));
      tick();
      start  = 1'b0;
      rd_req = 1'b0;
    end
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    build_sbox();
    repeat (3) tick();
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_done", 160'(done), 160'(0));
    check("rst_err", 160'(err), 160'(0));
    check("rst_keys_valid", 160'(keys_valid), 160'(0));
    check("rst_rk_valid", 160'(rk_valid), 160'(0));
    check("rst_rk", 160'(rk), 160'(0));
    rst = 1'b0;
    repeat (2) tick();

    // reserved length with nothing stored
    start_run(2'b11, rand_key(), 1'b0);
    repeat (2) tick();
    read_kat(4'd0, '0, ALL);

    // known-answer schedules
    run(2'b00, K128, 0);
    read_kat(4'd10, {1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6}, ALL);
    read_kat(4'd11, '0, ALL);
    read_all();

    run(2'b01, K192, 0);
    read_kat(4'd12, {1'b1, 96'h0, 32'h01002202}, LOWW);
    read_kat(4'd13, '0, ALL);
    read_all();

    // reserved length while a schedule is held: store and flag untouched
    start_run(2'b11, rand_key(), 1'b0);
    repeat (2) tick();
    read_all();

    run(2'b10, K256, 0);
    read_kat(4'd14, {1'b1, 96'h0, 32'h706c631e}, LOWW);
    read_all();

    // start pulses at E+5 and E+20 with a different key are ignored
    start_run(2'b00, K128, 1'b0);
    repeat (4) tick();
    start = 1'b1; key = rand_key(); key_len = 2'b01;
    tick();
    start = 1'b0;
    repeat (14) tick();
    start = 1'b1; key = rand_key(); key_len = 2'b10;
    tick();
    start = 1'b0;
    wait_done();
    read_kat(4'd10, {1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6}, ALL);
    read_all();

    // asynchronous reset in the middle of an AES-256 run
    start_run(2'b10, K256, 1'b0);
    repeat (16) tick();
    rst = 1'b1;
    #2;
    check("abort_busy", 160'(busy), 160'(0));
    check("abort_done", 160'(done), 160'(0));
    check("abort_keys_valid", 160'(keys_valid), 160'(0));
    check("abort_rk_valid", 160'(rk_valid), 160'(0));
    done_q.delete();
    blen_q.delete();
    mdl_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (60) tick();
    read_kat(4'd0, '0, ALL);
    run(2'b00, K128, 0);
    read_kat(4'd10, {1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6}, ALL);
    read_all();

    // randomized schedules
    for (int r = 0; r < 8; r++) begin
      run(2'($urandom_range(0, 2)), rand_key(), int'($urandom_range(0, 2)));
      for (int q = 0; q < 6; q++) read_one(4'($urandom_range(0, 15)));
      tick();
      if (r % 3 == 0) begin
        start_run(2'b11, rand_key(), 1'b0);
        repeat (2) tick();
        read_all();
      end
    end

    repeat (4) tick();
    check("scoreboard_drain", 160'(exp_q.size() + done_q.size() + err_q.size()), 160'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
